// File: rtl/am2901_useq.sv
// am2901_useq: microprogram sequencer for an Am2901 bit slice.
// Fetches microwords from an external combinational control store, drives the
// slice pins while running, and handles conditional jumps, call/return through
// a small return-address stack, and a down-counting loop register.
module am2901_useq #(
  parameter int UPC_W       = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic              cp,
  input  logic              reset_lo,
  input  logic              start,
  input  logic [UPC_W-1:0]  start_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [UPC_W-1:0]  upc,
  input  logic [UPC_W+28:0] uword,
  output logic [8:0]        i,
  output logic [3:0]        a,
  output logic [3:0]        b,
  output logic [3:0]        d,
  output logic              cin,
  output logic              oe,
  input  logic              z,
  input  logic              ovr,
  input  logic              cout,
  input  logic              f3
);

  // Stack pointer must represent 0..STACK_DEPTH inclusive.
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [2:0] OP_CONT  = 3'd0;
  localparam logic [2:0] OP_JUMP  = 3'd1;
  localparam logic [2:0] OP_CALL  = 3'd2;
  localparam logic [2:0] OP_RET   = 3'd3;
  localparam logic [2:0] OP_LDCNT = 3'd4;
  localparam logic [2:0] OP_LOOP  = 3'd5;
  localparam logic [2:0] OP_HALT  = 3'd6;

  // Slice "no operation" opcode used whenever the sequencer is not running.
  localparam logic [8:0] NOP_I = 9'b001_000_100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [UPC_W-1:0]   r_upc;
  logic [UPC_W-1:0]   r_cnt;
  logic [SP_W-1:0]    r_sp;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [UPC_W-1:0]   r_stack [STACK_DEPTH];

  logic [2:0]         w_cond;
  logic [2:0]         w_op;
  logic [UPC_W-1:0]   w_br;
  logic [UPC_W-1:0]   w_upc_inc;
  logic               w_take;
  logic               w_push;
  logic [UPC_W-1:0]   w_top;

  assign w_cond    = uword[25:23];
  assign w_op      = uword[28:26];
  assign w_br      = uword[UPC_W+28:29];
  assign w_upc_inc = r_upc + 1'b1;

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign upc  = r_upc;

  // Evaluate the branch condition of the current microword from live status.
  always_comb begin
    w_take = 1'b0;
    case (w_cond)
      3'd0:    w_take = 1'b1;
      3'd1:    w_take = z;
      3'd2:    w_take = ~z;
      3'd3:    w_take = ovr;
      3'd4:    w_take = cout;
      3'd5:    w_take = f3;
      3'd6:    w_take = (r_cnt != '0);
      default: w_take = 1'b0;
    endcase
  end

  // A push only happens for a taken CALL that has room on the stack.
  assign w_push = (r_state == S_RUN) && (w_op == OP_CALL) && w_take && (r_sp != SP_FULL);

  // Select the top-of-stack entry (entry sp-1); zero when the stack is empty.
  always_comb begin
    w_top = '0;
    for (int k = 0; k < STACK_DEPTH; k++) begin
      if (r_sp == SP_W'(k + 1)) w_top = r_stack[k];
    end
  end

  // Slice pins: microword fields while running, a harmless NOP otherwise.
  // Driven from the state register so an async reset forces NOP immediately.
  always_comb begin
    i   = NOP_I;
    a   = 4'd0;
    b   = 4'd0;
    d   = 4'd0;
    cin = 1'b0;
    oe  = 1'b1;
    if (r_state == S_RUN) begin
      i   = uword[8:0];
      a   = uword[12:9];
      b   = uword[16:13];
      d   = uword[20:17];
      cin = uword[21];
      oe  = uword[22];
    end
  end

  // Return-address stack storage: write the return address at slot sp on a push.
  always_ff @(posedge cp or negedge reset_lo) begin
    if (!reset_lo) begin
      for (int k = 0; k < STACK_DEPTH; k++) r_stack[k] <= '0;
    end else if (w_push) begin
      for (int k = 0; k < STACK_DEPTH; k++) begin
        if (r_sp == SP_W'(k)) r_stack[k] <= w_upc_inc;
      end
    end
  end

  // Sequencer FSM: state, micro-PC, loop counter, stack pointer and host flags.
  always_ff @(posedge cp or negedge reset_lo) begin
    if (!reset_lo) begin
      r_state <= S_IDLE;
      r_upc   <= '0;
      r_cnt   <= '0;
      r_sp    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_upc   <= start_addr;
            r_err   <= 1'b0;
          end
        end

        S_RUN: begin
          case (w_op)
            OP_JUMP: begin
              r_upc <= w_take ? w_br : w_upc_inc;
            end
            OP_CALL: begin
              if (w_take) begin
                if (r_sp == SP_FULL) begin
                  // Overflow: abort with upc and stack left as they were.
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                end else begin
                  r_sp  <= r_sp + 1'b1;
                  r_upc <= w_br;
                end
              end else begin
                r_upc <= w_upc_inc;
              end
            end
            OP_RET: begin
              if (w_take) begin
                if (r_sp == '0) begin
                  // Underflow: nothing to return to, abort the run.
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                end else begin
                  r_sp  <= r_sp - 1'b1;
                  r_upc <= w_top;
                end
              end else begin
                r_upc <= w_upc_inc;
              end
            end
            OP_LDCNT: begin
              r_cnt <= w_br;
              r_upc <= w_upc_inc;
            end
            OP_LOOP: begin
              if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
                r_upc <= w_br;
              end else begin
                r_upc <= w_upc_inc;
              end
            end
            OP_HALT: begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
            default: begin
              // CONT and the spare opcode both fall through to the next word.
              r_upc <= w_upc_inc;
            end
          endcase
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_am2901_useq.sv
// tb_am2901_useq: directed plus randomized bench for the microprogram sequencer.
// A queue-based reference model tracks state, micro-PC, loop counter and stack.
module tb_am2901_useq;

  localparam int UPC_W = 6;
  localparam int DEPTH = 64;
  localparam int SDEP  = 4;

  logic              cp;
  logic              reset_lo;
  logic              start;
  logic [UPC_W-1:0]  start_addr;
  logic              busy, done, err;
  logic [UPC_W-1:0]  upc;
  logic [UPC_W+28:0] uword;
  logic [8:0]        i;
  logic [3:0]        a, b, d;
  logic              cin, oe;
  logic              z, ovr, cout, f3;

  logic [34:0] rom [DEPTH];
  assign uword = rom[upc];

  am2901_useq #(.UPC_W(UPC_W), .STACK_DEPTH(SDEP)) dut (
    .cp(cp), .reset_lo(reset_lo), .start(start), .start_addr(start_addr),
    .busy(busy), .done(done), .err(err), .upc(upc), .uword(uword),
    .i(i), .a(a), .b(b), .d(d), .cin(cin), .oe(oe),
    .z(z), .ovr(ovr), .cout(cout), .f3(f3)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 run, 2 done.
  int m_state;
  int m_upc;
  int m_cnt;
  int m_stack[$];
  bit m_err;

  bit hold_st;
  int q_upc[$];
  int e[$];

  function automatic logic [34:0] mw(input int op, input int cond, input int br);
    logic [34:0] w;
    w = 35'($urandom) & 35'h7F_FFFF;
    w = w | (35'(cond) << 23) | (35'(op) << 26) | (35'(br) << 29);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_upc   = 0;
    m_cnt   = 0;
    m_err   = 0;
    m_stack.delete();
  endtask

  task automatic check_outputs();
    logic [34:0] w;
    bit run;
    w   = rom[m_upc];
    run = (m_state == 1);
    chk("busy", 32'(busy), 32'(run));
    chk("done", 32'(done), 32'(m_state == 2));
    chk("err",  32'(err),  32'(m_err));
    chk("upc",  32'(upc),  32'(m_upc));
    chk("i",    32'(i),    run ? 32'(w & 35'h1FF)       : 32'h044);
    chk("a",    32'(a),    run ? 32'((w >> 9) & 35'hF)  : 32'h0);
    chk("b",    32'(b),    run ? 32'((w >> 13) & 35'hF) : 32'h0);
    chk("d",    32'(d),    run ? 32'((w >> 17) & 35'hF) : 32'h0);
    chk("cin",  32'(cin),  run ? 32'((w >> 21) & 35'h1) : 32'h0);
    chk("oe",   32'(oe),   run ? 32'((w >> 22) & 35'h1) : 32'h1);
  endtask

  task automatic model_step();
    logic [34:0] w;
    int op, cond, br, inc;
    bit take;
    w    = rom[m_upc];
    op   = int'((w >> 26) & 35'd7);
    cond = int'((w >> 23) & 35'd7);
    br   = int'(w >> 29);
    inc  = (m_upc + 1) % DEPTH;
    case (cond)
      0: take = 1;
      1: take = z;
      2: take = !z;
      3: take = ovr;
      4: take = cout;
      5: take = f3;
      6: take = (m_cnt != 0);
      default: take = 0;
    endcase
    if (m_state == 0) begin
      if (start) begin
        m_state = 1;
        m_upc   = int'(start_addr);
        m_err   = 0;
      end
    end else if (m_state == 2) begin
      m_state = 0;
    end else begin
      case (op)
        1: m_upc = take ? br : inc;
        2: begin
          if (!take) m_upc = inc;
          else if (m_stack.size() == SDEP) begin m_err = 1; m_state = 0; end
          else begin m_stack.push_back(inc); m_upc = br; end
        end
        3: begin
          if (!take) m_upc = inc;
          else if (m_stack.size() == 0) begin m_err = 1; m_state = 0; end
          else m_upc = m_stack.pop_back();
        end
        4: begin m_cnt = br; m_upc = inc; end
        5: begin
          if (m_cnt != 0) begin m_cnt = m_cnt - 1; m_upc = br; end
          else m_upc = inc;
        end
        6: m_state = 2;
        default: m_upc = inc;
      endcase
    end
  endtask

  // One clock cycle: drive status, compare against the model, advance both.
  task automatic tick();
    if (!hold_st) begin
      z    = 1'($urandom & 1);
      ovr  = 1'($urandom & 1);
      cout = 1'($urandom & 1);
      f3   = 1'($urandom & 1);
    end
    #1;
    check_outputs();
    if (busy === 1'b1) q_upc.push_back(int'(upc));
    $display("[TB] t=%0t start=%0b upc=%0d busy=%0b done=%0b err=%0b i=%03h",
             $time, start, upc, busy, done, err, i);
    model_step();
    @(posedge cp);
    #1;
  endtask

  // Asynchronous reset between clock edges; outputs must react with no edge.
  task automatic do_reset();
    reset_lo = 1'b0;
    model_reset();
    q_upc.delete();
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_upc",  32'(upc),  32'h0);
    chk("rst_i",    32'(i),    32'h044);
    chk("rst_err",  32'(err),  32'h0);
    check_outputs();
    #1;
    reset_lo = 1'b1;
  endtask

  task automatic run_prog(input int addr, input int maxc);
    q_upc.delete();
    start_addr = UPC_W'(addr);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < maxc && m_state != 0; c++) tick();
  endtask

  task automatic chk_trace(input string tag, input int exp[$]);
    chk({tag, "_len"}, 32'(q_upc.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < q_upc.size(); k++)
      chk(tag, 32'(q_upc[k]), 32'(exp[k]));
  endtask

  initial begin
    reset_lo = 1'b0;
    start = 1'b0;
    start_addr = '0;
    hold_st = 1'b0;
    z = 0; ovr = 0; cout = 0; f3 = 0;
    for (int k = 0; k < DEPTH; k++) rom[k] = mw(6, 0, 0);
    model_reset();
    #2;
    check_outputs();
    reset_lo = 1'b1;
    @(posedge cp);
    #1;
    tick();

    // Straight line: CONT then HALT.
    rom[5] = mw(0, $urandom % 8, $urandom % 64);
    rom[6] = mw(6, 0, 0);
    run_prog(5, 10);
    e = {5, 6};
    chk_trace("t2_trace", e);

    // Conditional JUMP on z, taken and not taken.
    rom[8]  = mw(1, 1, 20);
    rom[20] = mw(6, 0, 0);
    rom[9]  = mw(6, 0, 0);
    hold_st = 1'b1;
    z = 1'b1;
    run_prog(8, 10);
    e = {8, 20};
    chk_trace("t3_taken", e);
    z = 1'b0;
    run_prog(8, 10);
    e = {8, 9};
    chk_trace("t3_fall", e);
    hold_st = 1'b0;

    // Loop counter: LDCNT 3, LOOP to itself, then a LOOP that sees cnt=0.
    rom[10] = mw(4, 7, 3);
    rom[11] = mw(5, 7, 11);
    rom[12] = mw(5, 0, 40);
    rom[13] = mw(6, 0, 0);
    run_prog(10, 20);
    e = {10, 11, 11, 11, 11, 12, 13};
    chk_trace("t4_loop", e);

    // Four nested calls and four returns in LIFO order.
    rom[30] = mw(2, 0, 40);
    rom[31] = mw(6, 0, 0);
    rom[40] = mw(2, 0, 44);
    rom[41] = mw(3, 0, 0);
    rom[44] = mw(2, 0, 48);
    rom[45] = mw(3, 0, 0);
    rom[48] = mw(2, 0, 52);
    rom[49] = mw(3, 0, 0);
    rom[52] = mw(3, 0, 0);
    run_prog(30, 20);
    e = {30, 40, 44, 48, 52, 49, 45, 41, 31};
    chk_trace("t5_lifo", e);
    chk("t5_noerr", 32'(err), 32'h0);

    // Fifth nested call overflows.
    rom[52] = mw(2, 0, 56);
    run_prog(30, 20);
    e = {30, 40, 44, 48, 52};
    chk_trace("t5_ovf", e);
    chk("t5_ovf_err", 32'(err), 32'h1);
    chk("t5_ovf_busy", 32'(busy), 32'h0);
    tick();
    chk("t5_sticky", 32'(err), 32'h1);

    // Accepted start clears err; stack contents survive the start.
    run_prog(5, 10);
    chk("start_clr_err", 32'(err), 32'h0);

    // Reset in mid-run aborts at once.
    q_upc.delete();
    start_addr = 6'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    do_reset();
    tick();

    // Return with an empty stack underflows.
    rom[60] = mw(3, 0, 0);
    run_prog(60, 10);
    chk("t5_udf_err", 32'(err), 32'h1);
    chk("t5_udf_busy", 32'(busy), 32'h0);

    // Start ignored while running, and upc wraps 63 -> 0.
    rom[62] = mw(0, 7, 5);
    rom[63] = mw(0, 7, 5);
    rom[0]  = mw(6, 0, 0);
    q_upc.delete();
    start_addr = 6'd62;
    start = 1'b1;
    tick();
    start_addr = 6'd33;
    tick();
    tick();
    start = 1'b0;
    for (int c = 0; c < 10 && m_state != 0; c++) tick();
    e = {62, 63, 0};
    chk_trace("t6_wrap", e);

    // Randomized microprograms with random status, stray starts and resets.
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < DEPTH; k++)
        rom[k] = mw(($urandom % 5 == 0) ? 6 : int'($urandom % 8), int'($urandom % 8), int'($urandom % 64));
      start_addr = UPC_W'($urandom);
      start = 1'b1;
      tick();
      for (int c = 0; c < 40 && m_state != 0; c++) begin
        start = ($urandom % 6 == 0);
        start_addr = UPC_W'($urandom);
        tick();
      end
      start = 1'b0;
      if (m_state != 0 || ($urandom % 4 == 0)) do_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
